reg_file_4x8: RTL and testbench
===============================

Name: reg_file_4x8

Overview:
- Four-entry general-purpose register file for the gate-level CPU datapath.
- Sits directly downstream of the 2-to-4 address decoder.
- A decoder2to4 instance turns the 2-bit write address into one-hot register write strobes.
- Two independent combinational read ports feed the ALU operand buses; one synchronous write port takes the ALU/result bus.

Parameters:
- WIDTH, 8, data width of each register and of all data ports.
- ZERO_R0, 0, 1 = register 0 is hardwired to zero (writes discarded, reads return 0).
- BYPASS, 1, 1 = same-cycle write data is forwarded to any read port addressing the register being written.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- we  input  1  write enable.
- wa  input  2  write address, R0..R3.
- wd  input  WIDTH  write data.
- ra0  input  2  read address, port 0.
- rd0  output  WIDTH  read data, port 0 (combinational).
- ra1  input  2  read address, port 1.
- rd1  output  WIDTH  read data, port 1 (combinational).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n; there is no asynchronous path.
- Storage: 4 x WIDTH bits. Each bit is a D flip-flop with a 2:1 recirculation mux for enable; no clock gating.
- Write decode: wa drives a decoder2to4 instance (A1=wa[1], A0=wa[0]). Enable for register k = Dk AND we AND rst_n.
- Reset: on a rising edge with rst_n=0, all four registers load 0 regardless of we/wa/wd. Reset dominates write.
- Before the first reset edge, contents are undefined; the bench must apply reset for at least 1 edge.
- Write: on a rising edge with rst_n=1 and we=1, register[wa] <= wd. All other registers hold.
- Write latency: 1 cycle. The new value is visible on a read port from the cycle after the edge, or in the same cycle via bypass.
- we=0: no register changes; wa and wd are ignored.
- Read: rdN = register[raN], combinational, zero cycle latency. Both ports may address the same register simultaneously; both return the same value.
- Bypass (BYPASS=1): if we=1, rst_n=1 and raN==wa, then rdN = wd in the same cycle, independent per port.
- Bypass is suppressed while rst_n=0; reads then show current stored contents.
- ZERO_R0=1:
  - Register 0 is never written; its enable is forced 0.
  - Reads of address 0 return 0.
  - Bypass never applies to address 0.
  - Register 0 need not be implemented as flops.
- Reset mid-operation: a write asserted in the same cycle as rst_n=0 is lost. Next cycle, all reads return 0.
- Back-to-back writes to the same address: the last edge wins. No hazard between consecutive cycles.
- Outputs after reset: rd0 = rd1 = 0 for any addresses until a write occurs.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with we=1, wa=2, wd=8'hAA -> all registers 0; rd0/rd1 = 8'h00 for ra=0..3.
- Write/readback: write R1=8'h5A, R2=8'hC3, R3=8'hFF on consecutive edges, then set ra0=1, ra1=3 -> rd0=8'h5A, rd1=8'hFF. Then ra0=ra1=2 -> both 8'hC3.
- Bypass: R2=8'h10 stored; drive we=1, wa=2, wd=8'h77, ra0=2, ra1=1 -> rd0=8'h77 before the edge, rd1 unchanged. After the edge, with we=0, rd0=8'h77. Repeat with BYPASS=0 -> rd0=8'h10 before the edge.
- Write-enable low: we=0, wa=3, wd=8'h01 over 3 edges -> R3 keeps its prior value 8'hFF.
- ZERO_R0=1: write wa=0, wd=8'h99 -> rd0 with ra0=0 reads 8'h00 before and after the edge. With ZERO_R0=0, the same sequence reads 8'h99 after the edge.
- Reset mid-write: R1=8'h5A; on one edge drive rst_n=0 together with we=1, wa=1, wd=8'h33 -> next cycle R1 = 8'h00, not 8'h33.

Source files
------------

// File: rtl/reg_file_4x8_if.sv
// Operand/result bus of the 4-entry register file: one write port, two read ports.
// The master drives addresses and write data; the register file returns read data.
interface reg_file_4x8_if #(
   parameter int WIDTH = 8
);
   logic             we;
   logic [1:0]       wa;
   logic [WIDTH-1:0] wd;
   logic [1:0]       ra0;
   logic [WIDTH-1:0] rd0;
   logic [1:0]       ra1;
   logic [WIDTH-1:0] rd1;

   modport master (
      output we, wa, wd, ra0, ra1,
      input  rd0, rd1
   );

   modport slave (
      input  we, wa, wd, ra0, ra1,
      output rd0, rd1
   );
endinterface

// File: rtl/reg_file_4x8.sv
// Four-entry register file with a decoded synchronous write port and two
// combinational read ports, optional write-to-read bypass and hardwired-zero R0.
module decoder2to4 (
   input  logic A1,
   input  logic A0,
   output logic D0,
   output logic D1,
   output logic D2,
   output logic D3
);
   assign D0 = ~A1 & ~A0;
   assign D1 = ~A1 &  A0;
   assign D2 =  A1 & ~A0;
   assign D3 =  A1 &  A0;
endmodule

module reg_file_4x8 #(
   parameter int WIDTH   = 8,
   parameter bit ZERO_R0 = 1'b0,
   parameter bit BYPASS  = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   reg_file_4x8_if.slave bus
);
   logic [3:0]       dec;
   logic [3:0]       en;
   logic [WIDTH-1:0] regs_q [4];
   logic [WIDTH-1:0] regs_d [4];
   logic             wr_live;

   decoder2to4 u_dec (
      .A1 (bus.wa[1]),
      .A0 (bus.wa[0]),
      .D0 (dec[0]),
      .D1 (dec[1]),
      .D2 (dec[2]),
      .D3 (dec[3])
   );

   assign wr_live = bus.we & rst_n;

   // Reset dominates the enable: every register reloads zero while rst_n is low.
   always_comb begin
      for (int unsigned k = 0; k < 4; k++) begin
         en[k]     = dec[k] & wr_live & ~(ZERO_R0 && (k == 0));
         regs_d[k] = regs_q[k];
         if (!rst_n) begin
            regs_d[k] = '0;
         end else if (en[k]) begin
            regs_d[k] = bus.wd;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < 4; k++) begin
         regs_q[k] <= regs_d[k];
      end
   end

   always_comb begin
      bus.rd0 = regs_q[bus.ra0];
      if (ZERO_R0 && (bus.ra0 == 2'd0)) begin
         bus.rd0 = '0;
      end else if (BYPASS && wr_live && (bus.ra0 == bus.wa)) begin
         bus.rd0 = bus.wd;
      end
   end

   always_comb begin
      bus.rd1 = regs_q[bus.ra1];
      if (ZERO_R0 && (bus.ra1 == 2'd0)) begin
         bus.rd1 = '0;
      end else if (BYPASS && wr_live && (bus.ra1 == bus.wa)) begin
         bus.rd1 = bus.wd;
      end
   end
endmodule

// File: tb/tb_reg_file_4x8.sv
// Scoreboard bench: three register-file variants share one stimulus stream;
// expected read data is queued by the stimulus and checked at negedge by a monitor.
module tb_reg_file_4x8;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       we;
   logic [1:0] wa;
   logic [7:0] wd;
   logic [1:0] ra0;
   logic [1:0] ra1;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   // a: bypass, plain R0   b: no bypass, plain R0   c: bypass, zero R0
   reg_file_4x8_if #(.WIDTH(8)) a_if ();
   reg_file_4x8_if #(.WIDTH(8)) b_if ();
   reg_file_4x8_if #(.WIDTH(8)) c_if ();

   assign a_if.we = we;  assign a_if.wa = wa;  assign a_if.wd = wd;
   assign a_if.ra0 = ra0; assign a_if.ra1 = ra1;
   assign b_if.we = we;  assign b_if.wa = wa;  assign b_if.wd = wd;
   assign b_if.ra0 = ra0; assign b_if.ra1 = ra1;
   assign c_if.we = we;  assign c_if.wa = wa;  assign c_if.wd = wd;
   assign c_if.ra0 = ra0; assign c_if.ra1 = ra1;

   reg_file_4x8 #(.WIDTH(8), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
   reg_file_4x8 #(.WIDTH(8), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
   reg_file_4x8 #(.WIDTH(8), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));

   typedef struct {
      int         dut;
      logic [7:0] e0;
      logic [7:0] e1;
      string      name;
   } exp_t;

   exp_t q[$];

   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] g0, g1;
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.dut)
            0:       begin g0 = a_if.rd0; g1 = a_if.rd1; end
            1:       begin g0 = b_if.rd0; g1 = b_if.rd1; end
            default: begin g0 = c_if.rd0; g1 = c_if.rd1; end
         endcase
         tests++;
         if (g0 !== e.e0) begin
            failed++;
            $display("FAIL %s dut%0d rd0 got %h want %h", e.name, e.dut, g0, e.e0);
         end
         tests++;
         if (g1 !== e.e1) begin
            failed++;
            $display("FAIL %s dut%0d rd1 got %h want %h", e.name, e.dut, g1, e.e1);
         end
      end
   end

   task automatic drive(input logic r, input logic w, input logic [1:0] a,
                        input logic [7:0] d, input logic [1:0] r0, input logic [1:0] r1);
      rst_n = r; we = w; wa = a; wd = d; ra0 = r0; ra1 = r1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue expectations for the current inputs, let the monitor sample, then pass one edge.
   task automatic chk(input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] c0, input logic [7:0] c1, input string name);
      q.push_back('{0, a0, a1, name});
      q.push_back('{1, b0, b1, name});
      q.push_back('{2, c0, c1, name});
      @(negedge clk);
      tick();
   endtask

   initial begin
      drive(1'b0, 1'b1, 2'd2, 8'hAA, 2'd2, 2'd0);
      tick();
      chk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "reset_no_bypass");
      drive(1'b1, 1'b0, 2'd2, 8'hAA, 2'd0, 2'd1);
      chk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "reset_r0_r1");
      drive(1'b1, 1'b0, 2'd2, 8'hAA, 2'd2, 2'd3);
      chk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "reset_r2_r3");

      drive(1'b1, 1'b1, 2'd1, 8'h5A, 2'd0, 2'd0); tick();
      drive(1'b1, 1'b1, 2'd2, 8'hC3, 2'd0, 2'd0); tick();
      drive(1'b1, 1'b1, 2'd3, 8'hFF, 2'd0, 2'd0); tick();
      drive(1'b1, 1'b0, 2'd0, 8'h00, 2'd1, 2'd3);
      chk(8'h5A, 8'hFF, 8'h5A, 8'hFF, 8'h5A, 8'hFF, "readback_r1_r3");
      drive(1'b1, 1'b0, 2'd0, 8'h00, 2'd2, 2'd2);
      chk(8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hC3, "readback_same_r2");

      drive(1'b1, 1'b1, 2'd2, 8'h10, 2'd0, 2'd0); tick();
      drive(1'b1, 1'b1, 2'd2, 8'h77, 2'd2, 2'd1);
      chk(8'h77, 8'h5A, 8'h10, 8'h5A, 8'h77, 8'h5A, "bypass_before_edge");
      drive(1'b1, 1'b0, 2'd2, 8'h77, 2'd2, 2'd1);
      chk(8'h77, 8'h5A, 8'h77, 8'h5A, 8'h77, 8'h5A, "bypass_after_edge");

      drive(1'b1, 1'b0, 2'd3, 8'h01, 2'd3, 2'd3);
      tick(); tick();
      chk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, "we_low_hold");

      drive(1'b1, 1'b1, 2'd0, 8'h99, 2'd0, 2'd0);
      chk(8'h99, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, "r0_before_edge");
      drive(1'b1, 1'b0, 2'd0, 8'h99, 2'd0, 2'd0);
      chk(8'h99, 8'h99, 8'h99, 8'h99, 8'h00, 8'h00, "r0_after_edge");

      drive(1'b1, 1'b1, 2'd3, 8'h11, 2'd0, 2'd0); tick();
      drive(1'b1, 1'b1, 2'd3, 8'h22, 2'd0, 2'd0); tick();
      drive(1'b1, 1'b0, 2'd3, 8'h22, 2'd3, 2'd0);
      chk(8'h22, 8'h99, 8'h22, 8'h99, 8'h22, 8'h00, "back_to_back");

      drive(1'b0, 1'b1, 2'd1, 8'h33, 2'd1, 2'd3);
      chk(8'h5A, 8'h22, 8'h5A, 8'h22, 8'h5A, 8'h22, "reset_mid_write_before");
      drive(1'b1, 1'b0, 2'd1, 8'h33, 2'd1, 2'd3);
      chk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "reset_mid_write_r1_r3");
      drive(1'b1, 1'b0, 2'd1, 8'h33, 2'd0, 2'd2);
      chk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "reset_mid_write_r0_r2");

      @(negedge clk);
      #1;
      tests++;
      if (q.size() != 0) begin
         failed++;
         $display("FAIL scoreboard_drain left %0d want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
